dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder servicing the MIPS core's load/store port with a configurable access latency and a stall handshake. Replaces the zero-wait block RAM on the data side, so the pipeline can run against slower memory. Accepts one request at a time, holds the core via `stall` until the access completes, and returns registered read data with a one-cycle `ready` pulse.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 2: cycles from request acceptance to `ready`; must be at least 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  1: access request from the core, level, held until `ready`.
- `we`  in  1: 1 = store, 0 = load; sampled with `req`.
- `addr`  in  32: byte address; word index is `addr[log2(DEPTH)+1:2]`, upper bits are ignored (wrap).
- `wdata`  in  32: store data.
- `be`  in  4: byte enables; `be[i]` writes `wdata[8i+7:8i]`, little-endian; ignored on loads.
- `rdata`  out  32: load data, registered, valid while `ready`=1.
- `ready`  out  1: one-cycle completion pulse.
- `stall`  out  1: `req & ~ready`, combinational, to the pipeline hazard unit.
- `err`  out  1: misaligned-access flag, valid with `ready`.

## Operation
- States:
  - IDLE: `req`=1 → latch `we`/`addr`/`wdata`/`be`, load counter with `LATENCY-1`. Go to RESP if `LATENCY`=1, else BUSY.
  - BUSY: decrement counter; at 0 → RESP.
  - RESP: `ready`=1 → IDLE unconditionally.
- Loads: the array word is captured into `rdata` on the edge entering RESP. `rdata` holds its value until the next load completes.
- Stores: bytes are committed on the edge leaving RESP. `rdata` is unchanged by a store.
- Inputs that change during BUSY/RESP are ignored; only the latched copy is used.
- `req` still high in the cycle after RESP is a new request. Back-to-back accesses therefore cost `LATENCY+1` cycles each (one IDLE acceptance cycle).
- A load following a store to the same word returns the stored data, because the commit happens before the next acceptance.
- Reset: state → IDLE, counter → 0, `rdata` → 0, `ready` → 0, `err` → 0. An in-flight store is discarded. Array contents are not cleared. `stall` follows `req` after reset.

## Timing
- Cycle 0: `req` high in IDLE, so `stall`=1.
- Cycles 1..`LATENCY`-1: BUSY, `stall`=1.
- Cycle `LATENCY`: RESP, `ready`=1, `stall`=0, `rdata`/`err` valid.
- `ready` is never high for two consecutive cycles.
- A `rst` pulse during BUSY or RESP gives IDLE with `ready`=0 in the next cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A store with `addr[1:0]`≠0 commits nothing.
  - Any access with `addr[1:0]`≠0 completes normally in time, with `err`=1 during RESP; a load also returns `rdata`=0.
- Undefined: `addr[1:0]` is ignored, the access proceeds on the word index, and `err` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` (IDLE, BUSY, RESP);
  - width helper constant for the counter, `$clog2(LATENCY)` with a minimum of 1.
- Sub-module `dmem_array`: a `DEPTH`×32 register array with a byte-enable write port and a synchronous read port, instantiated once. The FSM, counter and request latch live in `dmem_responder`.

## Test plan
- Reset, then load at 0x00 with `LATENCY`=2 → `stall`=1 for cycles 0–1, `ready`=1 in cycle 2, `rdata`=0x00000000 on a cleared model.
- Store 0xDEADBEEF to 0x10 with `be`=4'b1111, then load 0x10 → `rdata`=0xDEADBEEF.
- Store 0x000000AA to 0x10 with `be`=4'b0001, then load → `rdata`=0xDEADBEAA.
- Load `addr`=0x400 with `DEPTH`=256 → same word as 0x000 (wrap).
- Assert `rst` in BUSY during a store of 0x12345678 to 0x20, then load 0x20 → old contents; `ready`=0 in the cycle after reset.
- With `DMEM_MISALIGN_TRAP_EN`, store to 0x22 → `err`=1 with `ready` and memory unchanged. Without it → word 0x20 is written and `err`=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and counter-width helper for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;
  function automatic int cnt_w(input int lat);
    return $clog2(lat) > 1 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word array with byte-enable write port and registered read port
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst || clr) rdata <= '0;
    else if (re) rdata <= mem[ridx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: latency-configurable data-memory responder with stall handshake; DMEM_MISALIGN_TRAP_EN enables misaligned-access trapping
import dmem_pkg::*;
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(LATENCY);
  dmem_state_t state;
  logic [CW-1:0] cnt;
  logic we_l, mis_l, mis_in, cur_we, cur_mis, acc, fin, wen;
  logic [AW-1:0] idx_l, cur_idx;
  logic [31:0] wdata_l;
  logic [3:0] be_l;
  logic addr_unused;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in = addr[1:0] != 2'b00;
`else
  assign mis_in = 1'b0;
`endif
  assign addr_unused = ^{addr[31:AW+2], addr[1:0]};
  assign acc = state == IDLE && req;
  assign fin = (acc && LATENCY == 1) || (state == BUSY && cnt == CW'(1));
  assign cur_we = state == IDLE ? we : we_l;
  assign cur_mis = state == IDLE ? mis_in : mis_l;
  assign cur_idx = state == IDLE ? addr[AW+1:2] : idx_l;
  assign wen = state == RESP && we_l && !mis_l && !rst;
  assign ready = state == RESP;
  assign stall = req && !ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state == IDLE ? (req ? (LATENCY == 1 ? RESP : BUSY) : IDLE) :
               state == BUSY ? (cnt == CW'(1) ? RESP : BUSY) : IDLE;
      cnt <= acc ? CW'(LATENCY - 1) : state == BUSY ? cnt - 1'b1 : cnt;
      err <= fin && cur_mis;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      we_l <= we;
      mis_l <= mis_in;
      idx_l <= addr[AW+1:2];
      wdata_l <= wdata;
      be_l <= be;
    end
  end
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .rst(rst),
    .we(wen),
    .widx(idx_l),
    .wdata(wdata_l),
    .be(be_l),
    .re(fin && !cur_we && !cur_mis),
    .clr(fin && !cur_we && cur_mis),
    .ridx(cur_idx),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LATENCY = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;
  logic clk = 1'b0;
  logic rst, req, we, ready, stall, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  logic [31:0] model [DEPTH];
  logic [31:0] rd_hold;
  exp_t sb [$];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .ready(ready), .stall(stall), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    logic mis;
    int cyc;
    mis = TRAP && a[1:0] != 2'b00;
    if (!w) rd_hold = mis ? 32'h0 : model[widx(a)];
    e.rd = rd_hold;
    e.er = mis;
    sb.push_back(e);
    if (w && !mis)
      for (int i = 0; i < 4; i++)
        if (b[i]) model[widx(a)][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    chk("ready_c0", {31'b0, ready}, 32'h0);
    cyc = 0;
    while (ready !== 1'b1 && cyc < LATENCY + 4) begin
      chk("stall_wait", {31'b0, stall}, 32'h1);
      @(negedge clk);
      #1;
      cyc++;
      we = ~w; addr = $urandom; wdata = $urandom; be = 4'($urandom);
    end
    chk("latency", 32'(cyc), 32'(LATENCY));
    e = sb.pop_front();
    chk("rdata", rdata, e.rd);
    chk("err", {31'b0, err}, {31'b0, e.er});
    chk("stall_resp", {31'b0, stall}, 32'h0);
    req = 1'b0;
  endtask
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; rd_hold = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_stall0", {31'b0, stall}, 32'h0);
    req = 1'b1;
    #1;
    chk("rst_stall1", {31'b0, stall}, 32'h1);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 32'h00, 32'h0000_0000, 4'hF);
    access(1'b1, 32'h20, 32'h0BAD_F00D, 4'hF);
    access(1'b0, 32'h00, 32'h0, 4'hF);
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    access(1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    access(1'b1, 32'h10, 32'h1122_3344, 4'b1010);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    access(1'b1, 32'h404, 32'h55AA_55AA, 4'hF);
    access(1'b0, 32'h04, 32'h0, 4'h0);
    access(1'b0, 32'h400, 32'h0, 4'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; be = 4'hF;
    @(negedge clk);
    #1;
    chk("busy_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready", {31'b0, ready}, 32'h0);
    chk("post_rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    rd_hold = 32'h0;
    access(1'b0, 32'h20, 32'h0, 4'h0);
    access(1'b1, 32'h22, 32'hCAFE_F00D, 4'hF);
    access(1'b0, 32'h20, 32'h0, 4'h0);
    access(1'b0, 32'h23, 32'h0, 4'h0);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
